// File: rtl/branch_resolver_if.sv
// ----------------------------------------------------------------------------
// branch_resolver_if
//   Request/response bundle between the ID-stage control and the branch
//   resolver.
//   master : ID-stage control. Drives the request, operands, PC and flush.
//            Receives stall, resolve, taken, target, busy and timeout.
//   slave  : branch_resolver. It sees the same signals in the opposite
//            direction.
//   Signals:
//     i_branch_valid       request qualifier (one cycle)
//     i_mode[2:0]          branch condition select
//     i_rs, i_rt           forwarded operand values
//     i_rs_ready,
//     i_rt_ready           operand holds its final value this cycle
//     i_pc_next            PC+4 of the branch
//     i_offset             sign-extended, pre-shifted immediate
//     i_flush              kill the in-flight branch
//     o_stall              hold IF/ID (combinational)
//     o_resolved           one-cycle result strobe
//     o_taken, o_target    registered result, held between resolves
//     o_busy               a branch is latched and unresolved
//     o_timeout            sticky operand-wait overrun flag
// ----------------------------------------------------------------------------
interface branch_resolver_if #(
  parameter int unsigned RBITS  = 32,
  parameter int unsigned PCBITS = 32
);

  logic              i_branch_valid;
  logic [2:0]        i_mode;
  logic [RBITS-1:0]  i_rs;
  logic [RBITS-1:0]  i_rt;
  logic              i_rs_ready;
  logic              i_rt_ready;
  logic [PCBITS-1:0] i_pc_next;
  logic [PCBITS-1:0] i_offset;
  logic              i_flush;

  logic              o_stall;
  logic              o_resolved;
  logic              o_taken;
  logic [PCBITS-1:0] o_target;
  logic              o_busy;
  logic              o_timeout;

  // ID-stage control side
  modport master (
    output i_branch_valid, i_mode, i_rs, i_rt, i_rs_ready, i_rt_ready,
           i_pc_next, i_offset, i_flush,
    input  o_stall, o_resolved, o_taken, o_target, o_busy, o_timeout
  );

  // Resolver side
  modport slave (
    input  i_branch_valid, i_mode, i_rs, i_rt, i_rs_ready, i_rt_ready,
           i_pc_next, i_offset, i_flush,
    output o_stall, o_resolved, o_taken, o_target, o_busy, o_timeout
  );

endinterface

// File: rtl/branch_resolver.sv
// ----------------------------------------------------------------------------
// branch_resolver
//   ID-stage branch resolution for six MIPS conditions: BEQ, BNE, BLEZ, BGTZ,
//   BLTZ and BGEZ. A request is accepted in IDLE or DONE. If the forwarded
//   operands it needs are not ready yet, the unit parks in WAIT and stalls
//   the front end until they are. The taken/target result is registered and
//   announced by a one-cycle o_resolved pulse in DONE. A flush from a later
//   stage drops the branch.
//
//   Parameters:
//     RBITS    register operand width
//     PCBITS   program counter / target width
//     MAX_WAIT operand-wait cycles tolerated before o_timeout is raised
//   Ports:
//     i_clk    rising-edge clock
//     i_reset  asynchronous, active-high reset
//     br       branch_resolver_if.slave (request, operands, flush, results)
// ----------------------------------------------------------------------------
module branch_resolver #(
  parameter int unsigned RBITS    = 32,
  parameter int unsigned PCBITS   = 32,
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic               i_clk,
  input  logic               i_reset,
  branch_resolver_if.slave   br
);

  // Counter must be able to hold MAX_WAIT+1 (its saturation value)
  localparam int unsigned CNT_W = $clog2(MAX_WAIT + 2);

  localparam logic [2:0] MODE_BEQ  = 3'b000;
  localparam logic [2:0] MODE_BNE  = 3'b001;
  localparam logic [2:0] MODE_BLEZ = 3'b010;
  localparam logic [2:0] MODE_BGTZ = 3'b011;
  localparam logic [2:0] MODE_BLTZ = 3'b100;
  localparam logic [2:0] MODE_BGEZ = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  state_e            state_q, state_d;
  logic [2:0]        mode_q, mode_d;
  logic [PCBITS-1:0] pc_q, pc_d;
  logic [PCBITS-1:0] off_q, off_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              taken_q, taken_d;
  logic [PCBITS-1:0] target_q, target_d;
  logic              timeout_q, timeout_d;

  logic              accept_c;
  logic              stall_c;
  logic              busy_c;

  // Operands the given mode needs. Reserved modes need none.
  function automatic logic ops_ready(input logic [2:0] mode,
                                     input logic       rs_rdy,
                                     input logic       rt_rdy);
    logic rdy;
    case (mode)
      MODE_BEQ, MODE_BNE:                       rdy = rs_rdy & rt_rdy;
      MODE_BLEZ, MODE_BGTZ, MODE_BLTZ, MODE_BGEZ: rdy = rs_rdy;
      default:                                  rdy = 1'b1;
    endcase
    return rdy;
  endfunction

  // Branch condition. The single-operand modes use a signed compare of rs
  // against zero, which reduces to the sign bit and an all-zero test.
  function automatic logic cond_taken(input logic [2:0]       mode,
                                      input logic [RBITS-1:0] rs,
                                      input logic [RBITS-1:0] rt);
    logic neg;
    logic zero;
    logic tk;
    neg  = rs[RBITS-1];
    zero = (rs == '0);
    case (mode)
      MODE_BEQ:  tk = (rs == rt);
      MODE_BNE:  tk = (rs != rt);
      MODE_BLEZ: tk = neg | zero;
      MODE_BGTZ: tk = ~neg & ~zero;
      MODE_BLTZ: tk = neg;
      MODE_BGEZ: tk = ~neg;
      default:   tk = 1'b0;
    endcase
    return tk;
  endfunction

  // State and datapath registers
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q   <= ST_IDLE;
      mode_q    <= 3'b000;
      pc_q      <= '0;
      off_q     <= '0;
      cnt_q     <= '0;
      taken_q   <= 1'b0;
      target_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      pc_q      <= pc_d;
      off_q     <= off_d;
      cnt_q     <= cnt_d;
      taken_q   <= taken_d;
      target_q  <= target_d;
      timeout_q <= timeout_d;
    end
  end

  // Next-state, datapath update and combinational stall/busy
  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    pc_d      = pc_q;
    off_d     = off_q;
    cnt_d     = cnt_q;
    taken_d   = taken_q;
    target_d  = target_q;
    timeout_d = timeout_q;
    stall_c   = 1'b0;
    busy_c    = 1'b0;

    // WAIT owns the latched branch. A request arriving with a flush, or
    // while reset is held, is never accepted.
    accept_c = br.i_branch_valid && !br.i_flush && !i_reset
               && (state_q != ST_WAIT);

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (accept_c) begin
          busy_c = 1'b1;
          mode_d = br.i_mode;
          pc_d   = br.i_pc_next;
          off_d  = br.i_offset;
          if (ops_ready(br.i_mode, br.i_rs_ready, br.i_rt_ready)) begin
            state_d  = ST_DONE;
            cnt_d    = '0;
            taken_d  = cond_taken(br.i_mode, br.i_rs, br.i_rt);
            target_d = br.i_pc_next + br.i_offset;
          end else begin
            // The accept cycle is already the first stalled cycle, so the
            // cleared counter counts it immediately.
            state_d = ST_WAIT;
            stall_c = 1'b1;
            cnt_d   = CNT_W'(1);
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_WAIT: begin
        busy_c = 1'b1;
        if (ops_ready(mode_q, br.i_rs_ready, br.i_rt_ready)) begin
          state_d  = ST_DONE;
          taken_d  = cond_taken(mode_q, br.i_rs, br.i_rt);
          target_d = pc_q + off_q;
        end else begin
          stall_c = 1'b1;
          if (cnt_q < CNT_W'(MAX_WAIT + 1)) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Flush overrides everything above. The branch is dropped and the
    // previous result is kept.
    if (br.i_flush) begin
      state_d  = ST_IDLE;
      mode_d   = mode_q;
      pc_d     = pc_q;
      off_d    = off_q;
      cnt_d    = cnt_q;
      taken_d  = taken_q;
      target_d = target_q;
      stall_c  = 1'b0;
      busy_c   = 1'b0;
    end

    // Sticky overrun flag. It only reports; the wait continues.
    timeout_d = timeout_q || (cnt_d > CNT_W'(MAX_WAIT));
  end

  assign br.o_stall    = stall_c;
  assign br.o_busy     = busy_c;
  assign br.o_resolved = (state_q == ST_DONE);
  assign br.o_taken    = taken_q;
  assign br.o_target   = target_q;
  assign br.o_timeout  = timeout_q;

endmodule

// File: tb/tb_branch_resolver.sv
// ----------------------------------------------------------------------------
// tb_branch_resolver
//   Directed stimulus for branch_resolver. Each accepted branch that is
//   expected to resolve pushes its hand-computed taken/target into a
//   scoreboard queue. A monitor pops one entry and compares it on every
//   o_resolved pulse. Stall, busy, timeout and reset behaviour are checked
//   inline by the stimulus process.
// ----------------------------------------------------------------------------
module tb_branch_resolver;

  localparam logic [2:0] BEQ  = 3'b000;
  localparam logic [2:0] BNE  = 3'b001;
  localparam logic [2:0] BGTZ = 3'b011;
  localparam logic [2:0] BLTZ = 3'b100;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  branch_resolver_if #(.RBITS(32), .PCBITS(32)) bif ();

  branch_resolver #(
    .RBITS    (32),
    .PCBITS   (32),
    .MAX_WAIT (15)
  ) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .br      (bif)
  );

  typedef struct packed {
    logic        taken;
    logic [31:0] target;
  } exp_t;

  exp_t exp_q[$];
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst && bif.o_resolved === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_resolve", 64'(exp_q.size()), 64'd1);
      end else begin
        e = exp_q.pop_front();
        chk("sb_taken",  64'(bif.o_taken),  64'(e.taken));
        chk("sb_target", 64'(bif.o_target), 64'(e.target));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  task automatic req(input logic [2:0] m, input logic [31:0] rs,
                     input logic [31:0] rt, input logic rsr, input logic rtr,
                     input logic [31:0] pc, input logic [31:0] off);
    bif.i_branch_valid = 1'b1;
    bif.i_mode         = m;
    bif.i_rs           = rs;
    bif.i_rt           = rt;
    bif.i_rs_ready     = rsr;
    bif.i_rt_ready     = rtr;
    bif.i_pc_next      = pc;
    bif.i_offset       = off;
  endtask

  task automatic expect_res(input logic t, input logic [31:0] tg);
    exp_t e;
    e.taken  = t;
    e.target = tg;
    exp_q.push_back(e);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_resolved"}, 64'(bif.o_resolved), 64'd0);
    chk({tag, "_taken"},    64'(bif.o_taken),    64'd0);
    chk({tag, "_target"},   64'(bif.o_target),   64'd0);
    chk({tag, "_stall"},    64'(bif.o_stall),    64'd0);
    chk({tag, "_busy"},     64'(bif.o_busy),     64'd0);
    chk({tag, "_timeout"},  64'(bif.o_timeout),  64'd0);
  endtask

  logic        exp_tab [4][3];
  logic [31:0] rsv     [3];

  initial begin
    rst                = 1'b1;
    bif.i_branch_valid = 1'b0;
    bif.i_mode         = 3'b000;
    bif.i_rs           = '0;
    bif.i_rt           = '0;
    bif.i_rs_ready     = 1'b0;
    bif.i_rt_ready     = 1'b0;
    bif.i_pc_next      = '0;
    bif.i_offset       = '0;
    bif.i_flush        = 1'b0;

    // rs = -1, 0, 1 ; rows BLEZ, BGTZ, BLTZ, BGEZ
    rsv[0] = 32'hFFFF_FFFF; rsv[1] = 32'h0; rsv[2] = 32'h1;
    exp_tab[0][0] = 1'b1; exp_tab[0][1] = 1'b1; exp_tab[0][2] = 1'b0;
    exp_tab[1][0] = 1'b0; exp_tab[1][1] = 1'b0; exp_tab[1][2] = 1'b1;
    exp_tab[2][0] = 1'b1; exp_tab[2][1] = 1'b0; exp_tab[2][2] = 1'b0;
    exp_tab[3][0] = 1'b0; exp_tab[3][1] = 1'b1; exp_tab[3][2] = 1'b1;

    #2;
    chk_all_zero("reset");
    tick();
    rst = 1'b0;
    tick();

    // BEQ both ready: resolves next cycle, no stall
    req(BEQ, 32'd5, 32'd5, 1'b1, 1'b1, 32'h100, 32'h20);
    expect_res(1'b1, 32'h120);
    neg();
    chk("t1_stall",    64'(bif.o_stall),    64'd0);
    chk("t1_busy",     64'(bif.o_busy),     64'd1);
    chk("t1_early",    64'(bif.o_resolved), 64'd0);
    tick();
    bif.i_branch_valid = 1'b0;
    neg();
    chk("t1_resolved", 64'(bif.o_resolved), 64'd1);
    chk("t1_stall2",   64'(bif.o_stall),    64'd0);
    tick();
    neg();
    chk("t1_pulse_end", 64'(bif.o_resolved), 64'd0);
    tick();

    // BNE with rt late by 3 cycles
    req(BNE, 32'd1, 32'd1, 1'b1, 1'b0, 32'h200, 32'h40);
    expect_res(1'b0, 32'h240);
    for (int i = 0; i < 3; i++) begin
      neg();
      chk("t2_stall",    64'(bif.o_stall),    64'd1);
      chk("t2_noresolve", 64'(bif.o_resolved), 64'd0);
      tick();
      bif.i_branch_valid = 1'b0;
    end
    bif.i_rt_ready = 1'b1;
    neg();
    chk("t2_stall_release", 64'(bif.o_stall), 64'd0);
    chk("t2_busy",          64'(bif.o_busy),  64'd1);
    tick();
    neg();
    chk("t2_resolved", 64'(bif.o_resolved), 64'd1);
    tick();

    // Signed single-operand modes; rt_ready low must not stall
    for (int m = 0; m < 4; m++) begin
      for (int k = 0; k < 3; k++) begin
        req(3'(m + 2), rsv[k], 32'h0, 1'b1, 1'b0, 32'h1000, 32'(k * 4));
        expect_res(exp_tab[m][k], 32'h1000 + 32'(k * 4));
        neg();
        chk("t3_stall", 64'(bif.o_stall), 64'd0);
        tick();
        bif.i_branch_valid = 1'b0;
        neg();
        chk("t3_resolved", 64'(bif.o_resolved), 64'd1);
        tick();
      end
    end

    // Reserved modes: no operands needed, not taken
    for (int r = 6; r < 8; r++) begin
      req(3'(r), 32'h0, 32'h0, 1'b0, 1'b0, 32'h40, 32'h4);
      expect_res(1'b0, 32'h44);
      neg();
      chk("t3_rsv_stall", 64'(bif.o_stall), 64'd0);
      tick();
      bif.i_branch_valid = 1'b0;
      neg();
      chk("t3_rsv_resolved", 64'(bif.o_resolved), 64'd1);
      tick();
    end

    // Target wrap-around
    req(BEQ, 32'd1, 32'd2, 1'b1, 1'b1, 32'hFFFF_FFF0, 32'h20);
    expect_res(1'b0, 32'h0000_0010);
    tick();
    bif.i_branch_valid = 1'b0;
    neg();
    chk("t4_resolved", 64'(bif.o_resolved), 64'd1);
    tick();

    // Flush in the 2nd WAIT cycle, with a competing request that is discarded
    req(BEQ, 32'd3, 32'd3, 1'b0, 1'b1, 32'h500, 32'h8);
    neg();
    chk("t5_stall_accept", 64'(bif.o_stall), 64'd1);
    tick();
    bif.i_branch_valid = 1'b0;
    neg();
    chk("t5_stall_wait1", 64'(bif.o_stall), 64'd1);
    tick();
    req(BEQ, 32'd9, 32'd9, 1'b1, 1'b1, 32'h540, 32'h8);
    bif.i_flush = 1'b1;
    neg();
    chk("t5_flush_stall", 64'(bif.o_stall), 64'd0);
    chk("t5_flush_busy",  64'(bif.o_busy),  64'd0);
    tick();
    bif.i_flush        = 1'b0;
    bif.i_branch_valid = 1'b0;
    neg();
    chk("t5_idle_resolved", 64'(bif.o_resolved), 64'd0);
    chk("t5_idle_busy",     64'(bif.o_busy),     64'd0);
    chk("t5_idle_stall",    64'(bif.o_stall),    64'd0);
    tick();
    neg();
    chk("t5_idle_resolved2", 64'(bif.o_resolved), 64'd0);
    tick();

    // Back-to-back accepts: second request taken in DONE
    req(BEQ, 32'd7, 32'd7, 1'b1, 1'b1, 32'h600, 32'h10);
    expect_res(1'b1, 32'h610);
    tick();
    req(BNE, 32'd7, 32'd8, 1'b1, 1'b1, 32'h700, 32'hFFFF_FFF0);
    expect_res(1'b1, 32'h6F0);
    neg();
    chk("t5_b2b_first",  64'(bif.o_resolved), 64'd1);
    chk("t5_b2b_busy",   64'(bif.o_busy),     64'd1);
    tick();
    bif.i_branch_valid = 1'b0;
    neg();
    chk("t5_b2b_second", 64'(bif.o_resolved), 64'd1);
    tick();
    neg();
    chk("t5_b2b_end",    64'(bif.o_resolved), 64'd0);
    tick();

    // rs late by 17 cycles: timeout visible from the 17th stalled cycle
    req(BGTZ, 32'd5, 32'd0, 1'b0, 1'b1, 32'h800, 32'h100);
    expect_res(1'b1, 32'h900);
    for (int c = 1; c <= 17; c++) begin
      neg();
      chk("t6_stall",   64'(bif.o_stall),   64'd1);
      chk("t6_timeout", 64'(bif.o_timeout), 64'(c >= 17));
      tick();
      bif.i_branch_valid = 1'b0;
    end
    bif.i_rs_ready = 1'b1;
    neg();
    chk("t6_stall_release", 64'(bif.o_stall),   64'd0);
    chk("t6_timeout_held",  64'(bif.o_timeout), 64'd1);
    tick();
    neg();
    chk("t6_resolved",        64'(bif.o_resolved), 64'd1);
    chk("t6_timeout_resolve", 64'(bif.o_timeout),  64'd1);
    tick();
    neg();
    chk("t6_timeout_sticky", 64'(bif.o_timeout), 64'd1);
    tick();

    // Asynchronous reset in the middle of a WAIT
    req(BLTZ, 32'h8000_0000, 32'h0, 1'b0, 1'b0, 32'h900, 32'h4);
    tick();
    bif.i_branch_valid = 1'b0;
    #2;
    chk("t6_pre_reset_busy", 64'(bif.o_busy), 64'd1);
    rst = 1'b1;
    #1;
    chk_all_zero("t6_async_reset");
    bif.i_rs_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    neg();
    chk("t6_post_reset_resolved", 64'(bif.o_resolved), 64'd0);
    chk("t6_post_reset_busy",     64'(bif.o_busy),     64'd0);
    tick();
    neg();
    chk("t6_post_reset_resolved2", 64'(bif.o_resolved), 64'd0);
    tick();

    chk("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
